// File: rtl/usb_pkg.sv
// Shared USB transmit definitions: FSM state type, header byte and packet sizes.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    CSUM   = 2'd3
  } tx_state_t;

  localparam logic [7:0] USB_HEADER_BYTE    = 8'hA5;
  localparam int         USB_WORD_BYTES     = 4;
  localparam int         USB_PKT_LEN_CSUM   = 1 + USB_WORD_BYTES + 1;
  localparam int         USB_PKT_LEN_NOCSUM = 1 + USB_WORD_BYTES;

endpackage

// File: rtl/usb_word_transmitter_if.sv
// Word-in / byte-out handshake bundle between the averaging logic, the
// transmitter and the USB endpoint logic.
interface usb_word_transmitter_if;
  logic        output_ready;
  logic [31:0] average_data;
  logic        word_accept;
  logic [7:0]  data_out;
  logic        shift_out;
  logic        tx_ready;
  logic        new_packet;
  logic        busy;

  modport master (
    output output_ready, average_data, tx_ready,
    input  word_accept, data_out, shift_out, new_packet, busy
  );

  modport slave (
    input  output_ready, average_data, tx_ready,
    output word_accept, data_out, shift_out, new_packet, busy
  );
endinterface

// File: rtl/usb_tx_checksum.sv
// Running 8-bit modulo-256 sum of the bytes of one packet.
module usb_tx_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = 8'h00;
    end else if (add_en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/usb_word_transmitter.sv
// Serializes one 32-bit word into a header + 4 data byte packet.
// Define USB_TX_CHECKSUM_EN to append a modulo-256 checksum byte.
module usb_word_transmitter
  import usb_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = USB_HEADER_BYTE,
  parameter bit         MSB_FIRST   = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  usb_word_transmitter_if.slave bus
);

  tx_state_t   state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        shift_out_q, shift_out_d;
  logic        new_packet_q, new_packet_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic        xfer;
  logic [7:0]  cur_byte;
  logic [7:0]  data_out_c;

  assign accept   = (state_q == IDLE) && bus.output_ready;
  assign xfer     = shift_out_q && bus.tx_ready;
  assign cur_byte = MSB_FIRST ? shreg_q[31:24] : shreg_q[7:0];

`ifdef USB_TX_CHECKSUM_EN
  logic [7:0] csum;

  // Header and data bytes are summed as they leave, so aborted bytes never count.
  usb_tx_checksum u_checksum (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .add_en (xfer && ((state_q == HEADER) || (state_q == DATA))),
    .din    (data_out_c),
    .sum    (csum)
  );
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.output_ready) begin
          shreg_d = bus.average_data;
          cnt_d   = 2'd0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          shreg_d = MSB_FIRST ? {shreg_q[23:0], 8'h00} : {8'h00, shreg_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'(USB_WORD_BYTES - 1)) begin
`ifdef USB_TX_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef USB_TX_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    shift_out_d  = (state_d != IDLE);
    busy_d       = (state_d != IDLE);
    new_packet_d = (state_d == HEADER);
  end

  always_comb begin
    data_out_c = 8'h00;
    case (state_q)
      HEADER:  data_out_c = HEADER_BYTE;
      DATA:    data_out_c = cur_byte;
`ifdef USB_TX_CHECKSUM_EN
      CSUM:    data_out_c = csum;
`endif
      default: data_out_c = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= 32'h0;
      cnt_q        <= 2'd0;
      shift_out_q  <= 1'b0;
      new_packet_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      shift_out_q  <= shift_out_d;
      new_packet_q <= new_packet_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.word_accept = accept;
  assign bus.data_out    = data_out_c;
  assign bus.shift_out   = shift_out_q;
  assign bus.new_packet  = new_packet_q;
  assign bus.busy        = busy_q;

endmodule
